// File: rtl/aes_ctrl_pkg.sv
// Shared types and constants for the AES request scheduler.
package aes_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_CLEAR,
    ST_RESP
  } state_t;

  localparam int TIMEOUT_DEFAULT = 64;
  localparam int ID_W            = 1;

endpackage

// File: rtl/aes_rr_arb2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the one not served last.
module aes_rr_arb2
  import aes_ctrl_pkg::*;
(
  input  logic [1:0]      valid,
  input  logic [ID_W-1:0] last_id,
  output logic [1:0]      grant
);

  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last_id != '0) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/aes_req_scheduler.sv
// Arbitrates two requesters onto a single AES engine, one block in flight,
// with an engine timeout that turns into an error response.
module aes_req_scheduler
  import aes_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int TW      = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [127:0] req0_plaintext,
  input  logic [127:0] req0_key,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [127:0] req1_plaintext,
  input  logic [127:0] req1_key,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [127:0] rsp_ciphertext,
  output logic         rsp_id,
  output logic         rsp_error,
  output logic         eng_start,
  output logic [127:0] eng_plaintext,
  output logic [127:0] eng_key,
  input  logic [127:0] eng_ciphertext,
  input  logic         eng_valid,
  output logic         eng_clear
);

  state_t          state, next_state;
  logic [TW-1:0]   timer;
  logic [127:0]    pt_q, key_q, ct_q;
  logic [ID_W-1:0] id_q, last_id;
  logic            err_q;
  logic [1:0]      grant;
  logic            accept;
  logic            timeout_hit;

  aes_rr_arb2 u_arb (
    .valid   ({req1_valid, req0_valid}),
    .last_id (last_id),
    .grant   (grant)
  );

  assign accept      = (state == ST_IDLE) && (grant != 2'b00);
  assign timeout_hit = (timer == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // Ready is masked by rst so nothing is offered while reset is held.
  always_comb begin
    next_state = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    eng_start  = 1'b0;
    eng_clear  = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      ST_IDLE: begin
        req0_ready = grant[0] && !rst;
        req1_ready = grant[1] && !rst;
        if (accept) next_state = ST_START;
      end
      ST_START: begin
        eng_start  = 1'b1;
        next_state = ST_WAIT;
      end
      ST_WAIT: begin
        if (eng_valid || timeout_hit) next_state = ST_CLEAR;
      end
      ST_CLEAR: begin
        eng_clear  = 1'b1;
        next_state = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // last_id resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pt_q    <= '0;
      key_q   <= '0;
      ct_q    <= '0;
      id_q    <= '0;
      err_q   <= 1'b0;
      timer   <= '0;
      last_id <= ID_W'(1);
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            pt_q  <= grant[1] ? req1_plaintext : req0_plaintext;
            key_q <= grant[1] ? req1_key : req0_key;
            id_q  <= ID_W'(grant[1]);
          end
        end
        ST_START: timer <= '0;
        ST_WAIT: begin
          timer <= timer + TW'(1);
          if (eng_valid) begin
            ct_q  <= eng_ciphertext;
            err_q <= 1'b0;
          end else if (timeout_hit) begin
            ct_q  <= '0;
            err_q <= 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) last_id <= id_q;
        end
        default: ;
      endcase
    end
  end

  assign eng_plaintext  = pt_q;
  assign eng_key        = key_q;
  assign rsp_ciphertext = ct_q;
  assign rsp_id         = id_q[0];
  assign rsp_error      = err_q;

endmodule

// File: tb/tb_aes_req_scheduler.sv
// Directed bench for aes_req_scheduler with an event-time reference model and a mock engine.
module tb_aes_req_scheduler;

  localparam int TIMEOUT = 16;
  localparam int TW      = 5;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req1_valid, req0_ready, req1_ready;
  logic [127:0] req0_plaintext, req0_key, req1_plaintext, req1_key;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_error;
  logic [127:0] rsp_ciphertext;
  logic         eng_start, eng_clear, eng_valid;
  logic [127:0] eng_plaintext, eng_key, eng_ciphertext;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int eng_lat = 5;

  aes_req_scheduler #(.TIMEOUT(TIMEOUT), .TW(TW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_plaintext(req0_plaintext), .req0_key(req0_key),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_plaintext(req1_plaintext), .req1_key(req1_key),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_ciphertext(rsp_ciphertext), .rsp_id(rsp_id), .rsp_error(rsp_error),
    .eng_start(eng_start), .eng_plaintext(eng_plaintext), .eng_key(eng_key),
    .eng_ciphertext(eng_ciphertext), .eng_valid(eng_valid), .eng_clear(eng_clear)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  // Mock engine: the FIPS-197 vector is answered exactly, anything else gets a fixed mixing function.
  function automatic logic [127:0] eng_fn(input logic [127:0] pt, input logic [127:0] key);
    if (pt == FIPS_PT && key == FIPS_KEY) return FIPS_CT;
    return pt ^ {key[63:0], key[127:64]} ^ 128'h5a5a_a5a5_0f0f_f0f0_1234_5678_9abc_def0;
  endfunction

  logic         e_busy;
  int           e_cnt;
  logic [127:0] e_res;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      e_busy <= 1'b0;
      e_cnt  <= 0;
      e_res  <= '0;
    end else if (eng_clear) begin
      e_busy <= 1'b0;
    end else if (eng_start) begin
      e_busy <= 1'b1;
      e_cnt  <= 1;
      e_res  <= eng_fn(eng_plaintext, eng_key);
    end else if (e_busy) begin
      e_cnt <= e_cnt + 1;
    end
  end

  assign eng_valid      = e_busy && (e_cnt >= eng_lat);
  assign eng_ciphertext = eng_valid ? e_res : '1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: tracks one block as a set of event times derived from the engine latency.
  logic         m_busy = 1'b0;
  logic         m_last = 1'b1;
  int           m_start, m_done;
  logic [127:0] m_pt, m_key, m_ct;
  logic         m_id, m_err;
  logic         e_r0, e_r1, e_rv, prev_rv = 1'b0;
  int n_start = 0, n_clear = 0, n_rise = 0, n_acc = 0;
  int t_start_last = 0, t_rise = 0, t_hs = 0, t_acc = 0;
  int served[$];

  always @(negedge clk) begin
    if (eng_start) begin n_start++; t_start_last = cyc; end
    if (eng_clear) n_clear++;
    if (rsp_valid && !prev_rv) begin n_rise++; t_rise = cyc; end
    if (rsp_valid && rsp_ready) begin t_hs = cyc; served.push_back(int'(rsp_id)); end
    if ((req0_ready && req0_valid) || (req1_ready && req1_valid)) begin n_acc++; t_acc = cyc; end
    prev_rv = rsp_valid;

    if (rst) begin
      chk("rst_req0_ready", req0_ready, 0);
      chk("rst_req1_ready", req1_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_ct", rsp_ciphertext, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_rsp_error", rsp_error, 0);
      chk("rst_eng_start", eng_start, 0);
      chk("rst_eng_clear", eng_clear, 0);
      chk("rst_eng_pt", eng_plaintext, 0);
      chk("rst_eng_key", eng_key, 0);
      m_busy = 1'b0;
      m_last = 1'b1;
    end else begin
      e_r0 = !m_busy && req0_valid && (!req1_valid || m_last);
      e_r1 = !m_busy && req1_valid && (!req0_valid || !m_last);
      e_rv = m_busy && (cyc >= m_done + 2);
      chk("req0_ready", req0_ready, e_r0);
      chk("req1_ready", req1_ready, e_r1);
      chk("ready_exclusive", req0_ready & req1_ready, 0);
      chk("eng_start", eng_start, m_busy && (cyc == m_start));
      chk("eng_clear", eng_clear, m_busy && (cyc == m_done + 1));
      chk("rsp_valid", rsp_valid, e_rv);
      if (m_busy && cyc >= m_start && cyc <= m_done + 1) begin
        chk("eng_plaintext", eng_plaintext, m_pt);
        chk("eng_key", eng_key, m_key);
      end
      if (e_rv) begin
        chk("rsp_ciphertext", rsp_ciphertext, m_ct);
        chk("rsp_id", rsp_id, m_id);
        chk("rsp_error", rsp_error, m_err);
        if (rsp_ready) begin
          m_busy = 1'b0;
          m_last = m_id;
        end
      end else if (e_r0 || e_r1) begin
        m_busy  = 1'b1;
        m_id    = e_r1;
        m_pt    = e_r1 ? req1_plaintext : req0_plaintext;
        m_key   = e_r1 ? req1_key : req0_key;
        m_start = cyc + 1;
        m_err   = eng_lat > TIMEOUT;
        m_done  = m_start + (m_err ? TIMEOUT : eng_lat);
        m_ct    = m_err ? 128'h0 : eng_fn(m_pt, m_key);
      end
    end
  end

  task automatic wait_accept(input int id);
    logic ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if ((id == 0 && req0_ready) || (id == 1 && req1_ready)) begin
        ok = 1'b1;
        break;
      end
    end
    chk("accept_within_bound", ok, 1);
    @(posedge clk);
    #1;
    if (id == 0) req0_valid = 1'b0;
    else         req1_valid = 1'b0;
  endtask

  task automatic send(input int id, input logic [127:0] pt, input logic [127:0] key);
    if (id == 0) begin
      req0_plaintext = pt; req0_key = key; req0_valid = 1'b1;
    end else begin
      req1_plaintext = pt; req1_key = key; req1_valid = 1'b1;
    end
    wait_accept(id);
  endtask

  task automatic wait_rsp(output logic [127:0] ct, output logic id, output logic err);
    logic ok = 1'b0;
    ct = '0; id = 1'b0; err = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) begin
        ct = rsp_ciphertext; id = rsp_id; err = rsp_error;
        ok = 1'b1;
        break;
      end
    end
    chk("response_within_bound", ok, 1);
    @(posedge clk);
    #1;
  endtask

  logic [127:0] g_ct;
  logic         g_id, g_err;
  int b_start, b_clear, b_srv, b_acc, b_rise, k;
  logic [127:0] p_a, p_b, k_a, k_b;

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_plaintext = '0; req0_key = '0; req1_plaintext = '0; req1_key = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Single FIPS-197 block
    b_start = n_start; b_clear = n_clear;
    eng_lat = 5;
    send(0, FIPS_PT, FIPS_KEY);
    wait_rsp(g_ct, g_id, g_err);
    chk("fips_ct", g_ct, FIPS_CT);
    chk("fips_id", g_id, 0);
    chk("fips_err", g_err, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("fips_start_pulses", n_start - b_start, 1);
    chk("fips_clear_pulses", n_clear - b_clear, 1);

    // Contention from a fresh reset
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    b_srv = served.size();
    eng_lat = 3;
    p_a = 128'hAAAA_0000_1111_2222_3333_4444_5555_6666; k_a = 128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100;
    p_b = 128'hBBBB_7777_8888_9999_AAAA_BBBB_CCCC_DDDD; k_b = 128'hFFEE_DDCC_BBAA_9988_7766_5544_3322_1100;
    req0_plaintext = p_a; req0_key = k_a; req1_plaintext = p_b; req1_key = k_b;
    req0_valid = 1'b1; req1_valid = 1'b1;
    k = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) k++;
      if (k == 4) break;
    end
    @(posedge clk);
    #1 req0_valid = 1'b0; req1_valid = 1'b0;
    chk("contention_count", k, 4);
    for (int j = 0; j < 4; j++) chk("contention_order", served[b_srv + j], j % 2);

    // Engine never answers
    eng_lat = 100000;
    send(0, p_b, k_a);
    wait_rsp(g_ct, g_id, g_err);
    chk("timeout_err", g_err, 1);
    chk("timeout_ct", g_ct, 0);
    chk("timeout_id", g_id, 0);
    chk("timeout_latency", t_rise - t_start_last, TIMEOUT + 2);

    // Engine answers on exactly the timeout cycle
    eng_lat = TIMEOUT;
    send(1, p_a, k_b);
    wait_rsp(g_ct, g_id, g_err);
    chk("race_err", g_err, 0);
    chk("race_ct", g_ct, eng_fn(p_a, k_b));
    chk("race_id", g_id, 1);
    chk("race_latency", t_rise - t_start_last, TIMEOUT + 2);

    // Response backpressure with a competing request
    rsp_ready = 1'b0;
    eng_lat = 2;
    send(0, p_a, k_a);
    b_acc = n_acc;
    req1_plaintext = p_b; req1_key = k_b; req1_valid = 1'b1;
    k = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (rsp_valid) begin k = 1; break; end
    end
    chk("bp_rsp_seen", k, 1);
    repeat (10) @(negedge clk);
    chk("bp_no_accept", n_acc - b_acc, 0);
    chk("bp_held_ct", rsp_ciphertext, eng_fn(p_a, k_a));
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    wait_accept(1);
    chk("bp_accept_gap", t_acc - t_hs, 1);
    wait_rsp(g_ct, g_id, g_err);
    chk("bp_next_id", g_id, 1);
    chk("bp_next_ct", g_ct, eng_fn(p_b, k_b));

    // Reset in the middle of WAIT
    eng_lat = 100000;
    send(0, p_b, k_b);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("abort_eng_key", eng_key, 0);
    chk("abort_rsp_valid", rsp_valid, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    b_rise = n_rise;
    repeat (30) @(posedge clk);
    #1;
    chk("abort_no_response", n_rise - b_rise, 0);
    eng_lat = 4;
    send(1, p_a, k_a);
    wait_rsp(g_ct, g_id, g_err);
    chk("after_abort_id", g_id, 1);
    chk("after_abort_err", g_err, 0);
    chk("after_abort_ct", g_ct, eng_fn(p_a, k_a));

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_req_scheduler.md
AES_REQ_SCHEDULER -- requirements
Module: aes_req_scheduler

Interface
REQ-001 Parameter: TIMEOUT, default 64, number of WAIT cycles allowed for the engine before an error response.
REQ-002 Parameter: TW, default 8, timer width, must satisfy 2^TW > TIMEOUT.
REQ-003 clk  in  1  single clock, all flops on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 req0_valid / req1_valid  in  1  requester N offers a block.
REQ-006 req0_ready / req1_ready  out  1  scheduler accepts requester N this cycle.
REQ-007 req0_plaintext / req1_plaintext  in  128  plaintext of requester N.
REQ-008 req0_key / req1_key  in  128  cipher key of requester N.
REQ-009 rsp_valid  out  1  response available.
REQ-010 rsp_ready  in  1  consumer accepts response.
REQ-011 rsp_ciphertext  out  128  result; zero on error.
REQ-012 rsp_id  out  1  requester index of the response.
REQ-013 rsp_error  out  1  engine timed out.
REQ-014 eng_start  out  1  one-cycle start pulse to the AES engine.
REQ-015 eng_plaintext / eng_key  out  128  engine operands.
REQ-016 eng_ciphertext  in  128  engine result.
REQ-017 eng_valid  in  1  engine result valid (level; engine holds it until cleared).
REQ-018 eng_clear  out  1  one-cycle pulse, ORed into the engine reset by the integrator to return it to idle.

Function
REQ-019 FSM states SHALL be IDLE, START, WAIT, CLEAR, RESP; only one block in flight.
REQ-020 IDLE: reqN_ready SHALL be 1 only for the granted requester; grant = the sole valid requester, or, if both are valid, the one not served last (round-robin pointer, reset value: requester 0 preferred).
REQ-021 IDLE: on reqN_valid && reqN_ready, plaintext, key and id SHALL be registered and the FSM SHALL go to START; otherwise it stays in IDLE.
REQ-022 START: eng_start = 1 for exactly one cycle, timer cleared to 0, next state WAIT.
REQ-023 eng_plaintext/eng_key SHALL be driven from the captured registers and stay stable from START through CLEAR.
REQ-024 WAIT: the timer SHALL increment each cycle; on eng_valid, eng_ciphertext is captured, error is cleared, and the FSM goes to CLEAR.
REQ-025 WAIT: if the timer reaches TIMEOUT-1 without eng_valid, ciphertext SHALL be captured as 0, error set to 1, and the FSM goes to CLEAR.
REQ-026 eng_valid and timeout in the same cycle: eng_valid wins (error = 0).
REQ-027 CLEAR: eng_clear = 1 for exactly one cycle, next state RESP.
REQ-028 RESP: rsp_valid = 1 with ciphertext/id/error held stable until rsp_ready; on the handshake, the round-robin pointer SHALL be updated to the served id and the FSM returns to IDLE.
REQ-029 No reqN_ready SHALL be asserted outside IDLE; eng_valid SHALL be ignored outside WAIT.
REQ-030 Latency: request handshake at cycle T -> eng_start at T+1; CLEAR one cycle after eng_valid is sampled; rsp_valid the cycle after CLEAR.
REQ-031 The earliest next request acceptance SHALL be one cycle after the response handshake.

Reset
REQ-032 On rst, the FSM SHALL go to IDLE and the pointer to prefer requester 0, and all outputs SHALL be 0 (including rsp_valid, eng_start, eng_clear, both ready signals, and the data buses).
REQ-033 A reset mid-operation SHALL abort the in-flight block with no response; the engine is reset by the same rst.

Structure
REQ-034 Shared package aes_ctrl_pkg SHALL hold the state enum type, the default TIMEOUT constant and the requester-id width.
REQ-035 One sub-module: aes_rr_arb2, a 2-way round-robin grant (valids + pointer -> grant one-hot).

Verification
REQ-036 Single request: req0 with plaintext 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f, on an AES-128 engine -> rsp_ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a, rsp_id 0, rsp_error 0, exactly one eng_start and one eng_clear pulse.
REQ-037 Contention: req0 and req1 both held valid for 4 transactions -> service order 0,1,0,1; ready never asserted to both requesters in the same cycle.
REQ-038 Timeout: engine model never asserts eng_valid -> rsp_error 1, rsp_ciphertext 0, rsp_valid exactly TIMEOUT+2 cycles after eng_start.
REQ-039 Race: eng_valid first asserted on the timeout cycle -> rsp_error 0 and ciphertext captured.
REQ-040 Backpressure: rsp_ready held low for 10 cycles -> rsp_* stable, req1_valid not accepted, accepted one cycle after the handshake.
REQ-041 Reset mid-WAIT -> all outputs 0 the next cycle; no response; a fresh req1 then completes normally.
